// File: rtl/matrix_mem_resp.sv
// -----------------------------------------------------------------------------
// matrix_mem_resp
// Memory-side responder for the matrix multiplier. It holds the operand tiles
// that the host preloads and streams them to the core one element per pulse.
// It also accepts 32-bit result words from the core into a result buffer that
// the host can read back.
//
// Optional build macro: TILE_ADDR_CHECK_EN
//   When it is defined, only tiles 0-3 (A) and 8-11 (B) are legal. Latching any
//   other tile sets the sticky addr_err output, and that tile reads back as
//   zero. When it is undefined, all 16 tiles are legal and addr_err is absent.
//
// Ports
//   clk, rstn           clock, asynchronous active-low reset
//   ld_en/addr/data     host preload of one element, addr = {tile, element}
//   ren, raddr          core read request and tile select
//   rdata, rready       element data and its one-cycle valid pulse
//   wen, wdata, wready  core write request, result word, one-cycle accept pulse
//   res_idx, res_data   host readback of the result buffer (combinational)
//   res_cnt             words stored since the last clear, saturating
//   res_clr             synchronous clear of write pointer, res_cnt and ovf
//   ovf                 sticky: a word was accepted while the buffer was full
//   addr_err            sticky illegal-tile flag (TILE_ADDR_CHECK_EN only)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transfer; ren is checked first, then wen
// RD_PULSE | rready high for one cycle, rdata holds the current element
// RD_WAIT  | RD_GAP idle cycles; at the end, continue the burst or go idle
// WR_PULSE | wready high; wdata is captured at the edge that ends it
// WR_WAIT  | WR_GAP idle cycles; at the end, continue the burst or go idle
// -----------------------------------------------------------------------------
module matrix_mem_resp #(
  parameter int RD_GAP    = 1,
  parameter int WR_GAP    = 1,
  parameter int RES_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         ld_en,
  input  logic [7:0]                   ld_addr,
  input  logic signed [15:0]           ld_data,
  input  logic                         ren,
  input  logic [3:0]                   raddr,
  output logic signed [15:0]           rdata,
  output logic                         rready,
  input  logic                         wen,
  input  logic [31:0]                  wdata,
  output logic                         wready,
  input  logic [$clog2(RES_DEPTH)-1:0] res_idx,
  output logic [31:0]                  res_data,
  output logic [$clog2(RES_DEPTH):0]   res_cnt,
  input  logic                         res_clr,
  output logic                         ovf
`ifdef TILE_ADDR_CHECK_EN
  ,
  output logic                         addr_err
`endif
);

  localparam int AW = $clog2(RES_DEPTH);
  localparam logic [AW:0] CNT_MAX   = (AW+1)'(RES_DEPTH);
  localparam logic [2:0]  RD_GAP_M1 = 3'(RD_GAP - 1);
  localparam logic [2:0]  WR_GAP_M1 = 3'(WR_GAP - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_PULSE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_PULSE = 3'd3,
    WR_WAIT  = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic signed [15:0] r_tile [256];
  logic [31:0]        r_res  [RES_DEPTH];

  logic [3:0]    r_cur_tile;
  logic [3:0]    r_elem;
  logic [2:0]    r_gap;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_res_cnt;
  logic          r_ovf;
  logic          r_rready;
  logic          r_wready;
  logic signed [15:0] r_rdata;

  logic       w_rd_start;   // load raddr as the new tile, element 0
  logic       w_rd_next;    // next element of the current tile
  logic       w_elem_inc;
  logic       w_elem_clr;
  logic       w_wr_fire;
  logic [3:0] w_rd_tile;
  logic [3:0] w_rd_elem;
  logic [7:0] w_rd_addr;
  logic       w_tile_ok;
  logic [AW-1:0] w_wr_idx;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_rd_start = 1'b0;
    w_rd_next  = 1'b0;
    w_elem_inc = 1'b0;
    w_elem_clr = 1'b0;
    w_wr_fire  = 1'b0;
    case (r_state)
      IDLE: begin
        if (ren) begin
          w_next     = RD_PULSE;
          w_rd_start = 1'b1;
        end else if (wen) begin
          w_next = WR_PULSE;
        end
      end
      RD_PULSE: begin
        w_next     = RD_WAIT;
        w_elem_inc = 1'b1;
      end
      RD_WAIT: begin
        if (r_gap == 3'd0) begin
          if (ren) begin
            w_next = RD_PULSE;
            // A tile change while streaming restarts at element 0 of the new tile.
            if (raddr != r_cur_tile) w_rd_start = 1'b1;
            else                     w_rd_next  = 1'b1;
          end else begin
            w_next     = IDLE;
            w_elem_clr = 1'b1;
          end
        end
      end
      WR_PULSE: begin
        w_next    = WR_WAIT;
        w_wr_fire = 1'b1;
      end
      WR_WAIT: begin
        // Reads waiting behind a write burst are served only after returning to IDLE.
        if (r_gap == 3'd0) w_next = wen ? WR_PULSE : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- gap timer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gap <= 3'd0;
    end else if (r_state == RD_PULSE) begin
      r_gap <= RD_GAP_M1;
    end else if (r_state == WR_PULSE) begin
      r_gap <= WR_GAP_M1;
    end else if (r_gap != 3'd0) begin
      r_gap <= r_gap - 3'd1;
    end
  end

  // ---------------------------------------------------------------- tile store
  always_ff @(posedge clk) begin
    if (ld_en) r_tile[ld_addr] <= ld_data;
  end

  assign w_rd_tile = w_rd_start ? raddr : r_cur_tile;
  assign w_rd_elem = w_rd_start ? 4'd0  : r_elem;
  assign w_rd_addr = {w_rd_tile, w_rd_elem};

`ifdef TILE_ADDR_CHECK_EN
  assign w_tile_ok = (w_rd_tile[3:2] == 2'b00) || (w_rd_tile[3:2] == 2'b10);
`else
  assign w_tile_ok = 1'b1;
`endif

  // ---------------------------------------------------------------- read path
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cur_tile <= 4'd0;
      r_elem     <= 4'd0;
      r_rdata    <= '0;
      r_rready   <= 1'b0;
    end else begin
      r_rready <= (w_next == RD_PULSE);
      if (w_rd_start) begin
        r_cur_tile <= raddr;
        r_elem     <= 4'd0;
      end else if (w_elem_inc) begin
        r_elem <= r_elem + 4'd1;   // wraps 15 -> 0
      end else if (w_elem_clr) begin
        r_elem <= 4'd0;
      end
      // The element is read on the edge that enters RD_PULSE, so a preload
      // on an earlier edge is seen and a preload on the same edge is not.
      if (w_rd_start || w_rd_next) begin
        r_rdata <= w_tile_ok ? r_tile[w_rd_addr] : '0;
      end
    end
  end

`ifdef TILE_ADDR_CHECK_EN
  logic r_addr_err;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr_err <= 1'b0;
    end else if (w_rd_start && !w_tile_ok) begin
      r_addr_err <= 1'b1;
    end else if (res_clr) begin
      r_addr_err <= 1'b0;
    end
  end
  assign addr_err = r_addr_err;
`endif

  // ---------------------------------------------------------------- write path
  // A clear on the same edge as a write puts that word at index 0 with count 1.
  assign w_wr_idx = res_clr ? '0 : r_wptr;

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_res[w_wr_idx] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr    <= '0;
      r_res_cnt <= '0;
      r_ovf     <= 1'b0;
      r_wready  <= 1'b0;
    end else begin
      r_wready <= (w_next == WR_PULSE);
      if (res_clr) begin
        r_wptr    <= w_wr_fire ? AW'(1) : '0;
        r_res_cnt <= w_wr_fire ? (AW+1)'(1) : '0;
        r_ovf     <= 1'b0;
      end else if (w_wr_fire) begin
        r_wptr <= r_wptr + AW'(1);   // wraps at RES_DEPTH
        if (r_res_cnt == CNT_MAX) r_ovf <= 1'b1;
        else                      r_res_cnt <= r_res_cnt + (AW+1)'(1);
      end
    end
  end

  assign res_data = r_res[res_idx];
  assign res_cnt  = r_res_cnt;
  assign ovf      = r_ovf;
  assign rdata    = r_rdata;
  assign rready   = r_rready;
  assign wready   = r_wready;

endmodule

// File: tb/tb_matrix_mem_resp.sv
module tb_matrix_mem_resp;

  logic               clk;
  logic               rstn;
  logic               ld_en;
  logic [7:0]         ld_addr;
  logic signed [15:0] ld_data;
  logic               ren;
  logic [3:0]         raddr;
  logic signed [15:0] rdata;
  logic               rready;
  logic               wen;
  logic [31:0]        wdata;
  logic               wready;
  logic [5:0]         res_idx;
  logic [31:0]        res_data;
  logic [6:0]         res_cnt;
  logic               res_clr;
  logic               ovf;

  int checks   = 0;
  int failures = 0;

  logic [15:0] rq[$];          // expected read elements, in order
  logic [31:0] exp_res[64];    // expected result buffer contents

  matrix_mem_resp #(.RD_GAP(1), .WR_GAP(1), .RES_DEPTH(64)) dut (
    .clk(clk), .rstn(rstn),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .ren(ren), .raddr(raddr), .rdata(rdata), .rready(rready),
    .wen(wen), .wdata(wdata), .wready(wready),
    .res_idx(res_idx), .res_data(res_data), .res_cnt(res_cnt),
    .res_clr(res_clr), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [3:0] tile, input int base);
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = {tile, 4'(e)};
      ld_data = 16'(base + e);
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL reset_rready got=%b exp=0", rready); end
    checks++; if (wready !== 1'b0) begin failures++; $display("FAIL reset_wready got=%b exp=0", wready); end
    checks++; if (rdata !== 16'sd0) begin failures++; $display("FAIL reset_rdata got=%0d exp=0", rdata); end
    checks++; if (res_cnt !== 7'd0) begin failures++; $display("FAIL reset_res_cnt got=%0d exp=0", res_cnt); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  // Tile 0 streamed for 17 pulses: 100..115 then wraps to 100.
  task automatic test_stream;
    int got = 0, cyc = 0, last = 0, holdbad = 0;
    logic [15:0] exp_v, lastv;
    rq.delete();
    for (int e = 0; e < 16; e++) rq.push_back(16'(100 + e));
    rq.push_back(16'd100);
    lastv = 16'd0;
    ren = 1'b1; raddr = 4'd0;
    while (got < 17 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (rready) begin
        exp_v = rq.pop_front();
        checks++; if (rdata !== exp_v) begin failures++; $display("FAIL stream_rdata pulse=%0d got=%0d exp=%0d", got, rdata, exp_v); end
        if (got == 0) begin
          checks++; if (cyc != 1) begin failures++; $display("FAIL stream_latency got=%0d exp=1", cyc); end
        end else begin
          checks++; if (cyc - last != 2) begin failures++; $display("FAIL stream_spacing got=%0d exp=2", cyc - last); end
        end
        last = cyc; lastv = exp_v; got++;
        if (got == 17) ren = 1'b0;
      end else if (got > 0 && rdata !== lastv) begin
        holdbad++;
      end
    end
    checks++; if (got != 17) begin failures++; $display("FAIL stream_timeout got=%0d exp=17", got); end
    checks++; if (holdbad != 0) begin failures++; $display("FAIL stream_rdata_hold got=%0d exp=0", holdbad); end
    holdbad = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (rready) holdbad++; end
    checks++; if (holdbad != 0) begin failures++; $display("FAIL stream_stop got=%0d exp=0", holdbad); end
  endtask

  // Tile 8 for five pulses, then raddr switches to 9 and restarts at element 0.
  task automatic test_tile_switch;
    int got = 0, cyc = 0;
    logic [15:0] exp_v;
    rq.delete();
    for (int e = 0; e < 5; e++) rq.push_back(16'(800 + e));
    rq.push_back(16'd900);
    rq.push_back(16'd901);
    ren = 1'b1; raddr = 4'd8;
    while (got < 7 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (rready) begin
        exp_v = rq.pop_front();
        checks++; if (rdata !== exp_v) begin failures++; $display("FAIL switch_rdata pulse=%0d got=%0d exp=%0d", got, rdata, exp_v); end
        got++;
        if (got == 5) raddr = 4'd9;
        if (got == 7) ren = 1'b0;
      end
    end
    checks++; if (got != 7) begin failures++; $display("FAIL switch_timeout got=%0d exp=7", got); end
    idle_cycles(3);
  endtask

  // ren and wen together: read first, write only after returning to IDLE.
  task automatic test_priority;
    int cyc = 0;
    logic [6:0] cnt0;
    cnt0 = res_cnt;
    ren = 1'b1; wen = 1'b1; raddr = 4'd0;
    @(negedge clk);
    checks++; if (rready !== 1'b1 || wready !== 1'b0) begin failures++; $display("FAIL prio_first rready=%b wready=%b exp rready=1 wready=0", rready, wready); end
    checks++; if (rdata !== 16'sd100) begin failures++; $display("FAIL prio_rdata got=%0d exp=100", rdata); end
    ren = 1'b0;
    cyc = 1;
    while (!wready && cyc < 30) begin @(negedge clk); cyc++; end
    checks++; if (cyc != 4) begin failures++; $display("FAIL prio_wready_cycle got=%0d exp=4", cyc); end
    wdata = 32'hABCD_1234;
    exp_res[cnt0[5:0]] = wdata;
    wen = 1'b0;
    idle_cycles(3);
    checks++; if (res_cnt !== cnt0 + 7'd1) begin failures++; $display("FAIL prio_res_cnt got=%0d exp=%0d", res_cnt, cnt0 + 7'd1); end
    res_idx = cnt0[5:0]; #1;
    checks++; if (res_data !== 32'hABCD_1234) begin failures++; $display("FAIL prio_res_data got=%h exp=abcd1234", res_data); end
  endtask

  // Clear, then 65 words: saturation at 64, overflow and wrap on the 65th.
  task automatic test_fill;
    int got = 0, cyc = 0, last = 0;
    @(negedge clk); res_clr = 1'b1;
    @(negedge clk); res_clr = 1'b0;
    checks++; if (res_cnt !== 7'd0 || ovf !== 1'b0) begin failures++; $display("FAIL clr_plain res_cnt=%0d ovf=%b exp 0/0", res_cnt, ovf); end
    wen = 1'b1;
    while (got < 65 && cyc < 500) begin
      @(negedge clk); cyc++;
      if (wready) begin
        if (got == 64) begin
          checks++; if (res_cnt !== 7'd64 || ovf !== 1'b0) begin failures++; $display("FAIL fill_64 res_cnt=%0d ovf=%b exp 64/0", res_cnt, ovf); end
        end
        if (got > 0) begin
          checks++; if (cyc - last != 2) begin failures++; $display("FAIL fill_spacing got=%0d exp=2", cyc - last); end
        end
        wdata = 32'(got);
        exp_res[got % 64] = 32'(got);
        last = cyc; got++;
        if (got == 65) wen = 1'b0;
      end
    end
    checks++; if (got != 65) begin failures++; $display("FAIL fill_timeout got=%0d exp=65", got); end
    idle_cycles(3);
    checks++; if (res_cnt !== 7'd64) begin failures++; $display("FAIL fill_sat got=%0d exp=64", res_cnt); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%b exp=1", ovf); end
    for (int i = 0; i < 64; i++) begin
      res_idx = 6'(i); #1;
      checks++; if (res_data !== exp_res[i]) begin failures++; $display("FAIL fill_data idx=%0d got=%0d exp=%0d", i, res_data, exp_res[i]); end
    end
  endtask

  // res_clr on the same edge that samples a write word.
  task automatic test_clr_same_edge;
    int cyc = 0;
    wen = 1'b1;
    while (!wready && cyc < 30) begin @(negedge clk); cyc++; end
    checks++; if (!wready) begin failures++; $display("FAIL clr_wait_timeout got=0 exp=1"); end
    wdata = 32'h5555_AAAA; res_clr = 1'b1; wen = 1'b0;
    @(negedge clk); res_clr = 1'b0;
    checks++; if (res_cnt !== 7'd1) begin failures++; $display("FAIL clr_edge_cnt got=%0d exp=1", res_cnt); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL clr_edge_ovf got=%b exp=0", ovf); end
    res_idx = 6'd0; #1;
    checks++; if (res_data !== 32'h5555_AAAA) begin failures++; $display("FAIL clr_edge_data got=%h exp=5555aaaa", res_data); end
    idle_cycles(2);
    wen = 1'b1; cyc = 0;
    while (!wready && cyc < 30) begin @(negedge clk); cyc++; end
    wdata = 32'h0BAD_F00D; wen = 1'b0;
    idle_cycles(3);
    checks++; if (res_cnt !== 7'd2) begin failures++; $display("FAIL clr_next_cnt got=%0d exp=2", res_cnt); end
    res_idx = 6'd1; #1;
    checks++; if (res_data !== 32'h0BAD_F00D) begin failures++; $display("FAIL clr_next_data got=%h exp=0badf00d", res_data); end
  endtask

  // Reset asserted during a read pulse; the next read restarts at element 0.
  task automatic test_reset_mid;
    int got = 0, cyc = 0;
    logic [15:0] exp_v;
    rq.delete();
    for (int e = 0; e < 4; e++) rq.push_back(16'(100 + e));
    ren = 1'b1; raddr = 4'd0;
    while (got < 4 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (rready) begin
        exp_v = rq.pop_front();
        checks++; if (rdata !== exp_v) begin failures++; $display("FAIL rstmid_rdata pulse=%0d got=%0d exp=%0d", got, rdata, exp_v); end
        got++;
      end
    end
    #2 rstn = 1'b0; ren = 1'b0;
    #1;
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL rstmid_async_rready got=%b exp=0", rready); end
    checks++; if (res_cnt !== 7'd0) begin failures++; $display("FAIL rstmid_res_cnt got=%0d exp=0", res_cnt); end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    ren = 1'b1; raddr = 4'd0; cyc = 0;
    while (!rready && cyc < 30) begin @(negedge clk); cyc++; end
    checks++; if (cyc != 1) begin failures++; $display("FAIL rstmid_latency got=%0d exp=1", cyc); end
    checks++; if (rdata !== 16'sd100) begin failures++; $display("FAIL rstmid_elem0 got=%0d exp=100", rdata); end
    ren = 1'b0;
    idle_cycles(3);
  endtask

  initial begin
    rstn = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    ren = 1'b0; raddr = '0; wen = 1'b0; wdata = '0;
    res_idx = '0; res_clr = 1'b0;
    for (int i = 0; i < 64; i++) exp_res[i] = '0;
    idle_cycles(3);
    test_reset();
    rstn = 1'b1;
    idle_cycles(2);
    preload(4'd0, 100);
    preload(4'd8, 800);
    preload(4'd9, 900);
    idle_cycles(2);
    test_stream();
    test_tile_switch();
    test_priority();
    test_fill();
    test_clr_same_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
